// File: rtl/qtr_scan_ctrl.sv
// Scan sequencer for an 8-channel QTR reflectance array: periodic stp pulse, eop collection with
// timeout, frame/line-bitmap capture and valid/ack hand-off. Macro QTR_LEDON_EN adds emitter control.
module qtr_scan_ctrl #(
  parameter int PERIOD_CYC  = 50000,
  parameter int STP_CYC     = 500,
  parameter int TIMEOUT_CYC = 3000,
  parameter int SETTLE_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  thr,
  input  logic [7:0]  eop_in,
  input  logic [63:0] qt_in,
  input  logic        ack,
`ifdef QTR_LEDON_EN
  output logic        ledon,
`endif
  output logic        stp,
  output logic [63:0] frame,
  output logic [7:0]  line_bits,
  output logic [7:0]  to_flags,
  output logic        valid,
  output logic        ovf,
  output logic        busy
);

  localparam int PH_MAX_A = (STP_CYC > TIMEOUT_CYC) ? STP_CYC : TIMEOUT_CYC;
  localparam int PH_MAX   = (PH_MAX_A > SETTLE_CYC) ? PH_MAX_A : SETTLE_CYC;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  // Period counter saturates; it must hold a stretched period without wrapping.
  localparam int PER_LIM  = PERIOD_CYC + STP_CYC + TIMEOUT_CYC + SETTLE_CYC + 2;
  localparam int PER_W    = $clog2(PER_LIM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_WAIT,
    S_CAPTURE,
    S_HOLD
`ifdef QTR_LEDON_EN
    , S_SETTLE
`endif
  } state_e;

`ifdef QTR_LEDON_EN
  localparam state_e S_START = S_SETTLE;
`else
  localparam state_e S_START = S_CHARGE;
`endif

  state_e      state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [PER_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]  done_q, done_d;
  logic [63:0] frame_q, frame_d, cap_frame;
  logic [7:0]  line_q, line_d, cap_line;
  logic [7:0]  to_q, to_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        stp_q, busy_q;
`ifdef QTR_LEDON_EN
  logic        ledon_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
    state_d   = state_q;
    ph_d      = ph_q + 1'b1;
    pcnt_d    = pcnt_q;
    done_d    = done_q;
    frame_d   = frame_q;
    line_d    = line_q;
    to_d      = to_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    cap_frame = '0;
    cap_line  = '0;
    if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;

    unique case (state_q)
      S_IDLE:    if (en) state_d = S_START;
`ifdef QTR_LEDON_EN
      S_SETTLE:  if (ph_q == PH_W'(SETTLE_CYC - 1)) state_d = S_CHARGE;
`endif
      S_CHARGE:  if (ph_q == PH_W'(STP_CYC - 1)) state_d = S_WAIT;
      S_WAIT:    if (done_q == 8'hFF || ph_q == PH_W'(TIMEOUT_CYC - 1)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_HOLD;
      // >= rather than == so an over-long scan stretches the period by leaving HOLD at once.
      S_HOLD:    if (pcnt_q >= PER_W'(PERIOD_CYC - 1)) state_d = en ? S_START : S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (state_d != state_q) ph_d = '0;
    if (state_d == S_START && state_q != S_START) pcnt_d = '0;
    if (state_q == S_WAIT) done_d = done_q | eop_in;
    if (state_d == S_CHARGE && state_q != S_CHARGE) done_d = '0;

    for (int i = 0; i < 8; i++) begin
      cap_frame[8*i +: 8] = done_q[i] ? qt_in[8*i +: 8] : 8'hFF;
      cap_line[i]         = (cap_frame[8*i +: 8] >= thr);
    end

    if (state_q == S_CAPTURE) begin
      frame_d = cap_frame;
      line_d  = cap_line;
      to_d    = ~done_q;
      valid_d = 1'b1;
      // A same-cycle ack consumes the older frame, so the overwrite is not an overflow.
      ovf_d   = (ovf_q | valid_q) & ~ack;
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      pcnt_q  <= '0;
      done_q  <= '0;
      frame_q <= '0;
      line_q  <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      stp_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef QTR_LEDON_EN
      ledon_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      ph_q    <= ph_d;
      pcnt_q  <= pcnt_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      line_q  <= line_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      stp_q   <= (state_d == S_CHARGE);
      busy_q  <= (state_d == S_CHARGE) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
`ifdef QTR_LEDON_EN
      ledon_q <= (state_d == S_SETTLE) || (state_d == S_CHARGE) || (state_d == S_WAIT);
`endif
    end
  end

  assign stp       = stp_q;
  assign frame     = frame_q;
  assign line_bits = line_q;
  assign to_flags  = to_q;
  assign valid     = valid_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
`ifdef QTR_LEDON_EN
  assign ledon     = ledon_q;
`endif

endmodule

// File: tb/tb_qtr_scan_ctrl.sv
// Self-checking bench for qtr_scan_ctrl: randomized eop arrival schedules checked against a
// frame-level reference model (arrival times -> capture time, done mask, frame, handshake flags).
`timescale 1ns/1ps
module tb_qtr_scan_ctrl;

  localparam int PERIOD = 200;
  localparam int STP    = 10;
  localparam int TMO    = 50;
  localparam int SETTLE = 10;
  localparam int NEVER  = 1000;

  logic        clk = 1'b0;
  logic        rst, en, ack;
  logic [7:0]  thr, eop_in;
  logic [63:0] qt_in;
  logic        stp, valid, ovf, busy;
  logic [63:0] frame;
  logic [7:0]  line_bits, to_flags;
`ifdef QTR_LEDON_EN
  logic        ledon;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int arr [8];
  bit m_valid, m_ovf, period_ok;
  int prev_rise;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qtr_scan_ctrl #(
    .PERIOD_CYC (PERIOD),
    .STP_CYC    (STP),
    .TIMEOUT_CYC(TMO),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .thr      (thr),
    .eop_in   (eop_in),
    .qt_in    (qt_in),
    .ack      (ack),
`ifdef QTR_LEDON_EN
    .ledon    (ledon),
`endif
    .stp      (stp),
    .frame    (frame),
    .line_bits(line_bits),
    .to_flags (to_flags),
    .valid    (valid),
    .ovf      (ovf),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full scan: waits for stp, drives eop per arr[], checks timing and the captured frame.
  task automatic run_scan(input bit ack_cap, input int drop_k, input string tag);
    int n, allk, lastw, led_seen;
    logic [7:0]  dm, lexp;
    logic [63:0] fexp;
    n = 0;
    led_seen = -1;
    while (stp !== 1'b1 && n < 4 * PERIOD) begin
`ifdef QTR_LEDON_EN
      if (ledon === 1'b1 && led_seen < 0) led_seen = cyc;
`endif
      step();
      n++;
    end
    checks++;
    if (stp !== 1'b1) begin
      errors++;
      $display("FAIL %s stp_start: no stp seen within %0d cycles", tag, n);
      return;
    end
`ifdef QTR_LEDON_EN
    checks++;
    if (led_seen < 0 || cyc - led_seen != SETTLE) begin
      errors++;
      $display("FAIL %s ledon_lead: ledon led stp by %0d cycles, required %0d", tag, cyc - led_seen, SETTLE);
    end
`endif
    if (period_ok) begin
      checks++;
      if (cyc - prev_rise != PERIOD) begin
        errors++;
        $display("FAIL %s period: %0d cycles between stp starts, required %0d", tag, cyc - prev_rise, PERIOD);
      end
    end
    prev_rise = cyc;

    n = 0;
    while (stp === 1'b1 && n < 4 * STP) begin
      n++;
      step();
    end
    checks++;
    if (n != STP) begin
      errors++;
      $display("FAIL %s stp_width: %0d cycles, required %0d", tag, n, STP);
    end

    // Reference: capture follows the cycle after all eops are seen, or the last timeout cycle.
    allk = 0;
    for (int i = 0; i < 8; i++) if (arr[i] > allk) allk = arr[i];
    lastw = (allk + 1 < TMO - 1) ? allk + 1 : TMO - 1;
    for (int i = 0; i < 8; i++) begin
      dm[i] = (arr[i] <= lastw);
      fexp[8*i +: 8] = dm[i] ? qt_in[8*i +: 8] : 8'hFF;
      lexp[i] = (fexp[8*i +: 8] >= thr);
    end

    for (int k = 0; k <= lastw + 1; k++) begin
      for (int i = 0; i < 8; i++) eop_in[i] = (arr[i] == k);
      if (k == drop_k) en = 1'b0;
`ifdef QTR_LEDON_EN
      if (k == lastw) begin
        checks++;
        if (ledon !== 1'b1) begin
          errors++;
          $display("FAIL %s ledon_wait: got %b required 1", tag, ledon);
        end
      end
`endif
      if (k == lastw + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s capture_busy: got %b required 1 at wait cycle %0d", tag, busy, k);
        end
`ifdef QTR_LEDON_EN
        checks++;
        if (ledon !== 1'b0) begin
          errors++;
          $display("FAIL %s ledon_capture: got %b required 0", tag, ledon);
        end
`endif
        ack = ack_cap;
      end
      step();
    end
    ack = 1'b0;
    eop_in = 8'h00;

    if (ack_cap) m_ovf = 1'b0;
    else if (m_valid) m_ovf = 1'b1;
    m_valid = 1'b1;

    checks++;
    if (frame !== fexp) begin
      errors++;
      $display("FAIL %s frame: got %h required %h", tag, frame, fexp);
    end
    checks++;
    if (line_bits !== lexp) begin
      errors++;
      $display("FAIL %s line_bits: got %h required %h", tag, line_bits, lexp);
    end
    checks++;
    if (to_flags !== ~dm) begin
      errors++;
      $display("FAIL %s to_flags: got %h required %h", tag, to_flags, ~dm);
    end
    checks++;
    if (valid !== m_valid || ovf !== m_ovf) begin
      errors++;
      $display("FAIL %s handshake: valid/ovf got %b%b required %b%b", tag, valid, ovf, m_valid, m_ovf);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s hold_busy: got %b required 0", tag, busy);
    end
    period_ok = (drop_k < 0) && (en === 1'b1);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_clear: valid/ovf got %b%b required 00", tag, valid, ovf);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({stp, valid, ovf, busy} !== 4'b0 || frame !== 64'h0 || line_bits !== 8'h0 || to_flags !== 8'h0) begin
      errors++;
      $display("FAIL %s outputs_zero: stp=%b valid=%b ovf=%b busy=%b frame=%h line=%h to=%h",
               tag, stp, valid, ovf, busy, frame, line_bits, to_flags);
    end
`ifdef QTR_LEDON_EN
    checks++;
    if (ledon !== 1'b0) begin
      errors++;
      $display("FAIL %s ledon_zero: got %b required 0", tag, ledon);
    end
`endif
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; en = 1'b0; ack = 1'b0; thr = 8'h00; eop_in = 8'h00; qt_in = '0;
    m_valid = 1'b0; m_ovf = 1'b0; period_ok = 1'b0; prev_rise = 0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      if (stp !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_no_en: stp/busy high on %0d cycles, required 0", bad);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      arr[i] = 5;
      qt_in[8*i +: 8] = 8'(8'h10 * (i + 1));
    end
    thr = 8'h40;
    en = 1'b1;
    run_scan(1'b0, -1, "basic");
    checks++;
    if (line_bits !== 8'hF8 || to_flags !== 8'h00) begin
      errors++;
      $display("FAIL basic_literal: line/to got %h/%h required f8/00", line_bits, to_flags);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 8; i++) arr[i] = 5;
    arr[3] = NEVER;
    run_scan(1'b0, -1, "timeout");
    checks++;
    if (to_flags !== 8'h08 || frame[31:24] !== 8'hFF || line_bits[3] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_literal: to=%h byte3=%h line3=%b required 08/ff/1", to_flags, frame[31:24], line_bits[3]);
    end
    do_ack("timeout");
  endtask

  task automatic randomize_scan();
    for (int i = 0; i < 8; i++) begin
      arr[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, TMO + 5));
      qt_in[8*i +: 8] = 8'($urandom);
    end
    thr = 8'($urandom);
  endtask

  task automatic test_overflow();
    randomize_scan();
    run_scan(1'b0, -1, "ovf_first");
    randomize_scan();
    run_scan(1'b0, -1, "ovf_second");
    checks++;
    if (ovf !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: valid/ovf got %b%b required 11", valid, ovf);
    end
    do_ack("ovf");
  endtask

  task automatic test_ack_on_capture();
    randomize_scan();
    run_scan(1'b0, -1, "ackcap_first");
    randomize_scan();
    run_scan(1'b1, -1, "ackcap_second");
    checks++;
    if (valid !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ack_on_capture: valid/ovf got %b%b required 10", valid, ovf);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      randomize_scan();
      if (s == 0) for (int i = 0; i < 8; i++) arr[i] = TMO - 2 + (i % 2);
      run_scan(($urandom_range(0, 3) == 0), -1, "random");
      if ($urandom_range(0, 1) == 1) do_ack("random");
    end
  endtask

  task automatic test_en_drop();
    int bad;
    randomize_scan();
    run_scan(1'b0, 2, "en_drop");
    bad = 0;
    repeat (3 * PERIOD + 20) begin
      step();
      if (stp !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_drop_idle: stp/busy high on %0d cycles, required 0", bad);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_frame: valid got %b required 1", valid);
    end
    period_ok = 1'b0;
  endtask

  task automatic test_reset_mid_charge();
    int n;
    en = 1'b1;
    n = 0;
    while (stp !== 1'b1 && n < 4 * PERIOD) begin
      step();
      n++;
    end
    checks++;
    if (stp !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_start: no stp within %0d cycles", n);
    end
    repeat (3) step();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_charge");
    step();
    rst = 1'b0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    period_ok = 1'b0;
    randomize_scan();
    run_scan(1'b0, -1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_ack_on_capture();
    test_random();
    test_en_drop();
    test_reset_mid_charge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
